// File: rtl/alu_cc_unit.sv
// alu_cc_unit
// Execute stage fed by the register file. Selects operand B (register or
// sign-extended imm5), runs single-cycle ALU ops or a DATA_W-iteration
// shift-add multiply behind a start/done handshake, and owns the NZP
// condition codes and the BEN branch-enable flag.
//
// Ports:
//   Clk        clock, rising edge
//   Reset_al   synchronous active-low reset
//   start      request, sampled only in IDLE
//   ALUK       00 ADD, 01 AND, 10 NOT(A), 11 PASS(A)
//   MUL        multiply instead of ALUK when high at start
//   SR1_OUT    operand A
//   SR2_OUT    register operand B
//   IR         instruction: [5] SR2MUX select, [4:0] imm5, [11:9] nzp mask
//   bus_data   value used for condition-code update
//   LD_CC      load NZP from bus_data
//   LD_BEN     load BEN from IR[11:9] & NZP
//   ALU_out    registered result, held until the next completion
//   busy       high while not IDLE
//   done       one-cycle completion pulse
//   NZP        condition codes {N,Z,P}
//   BEN        branch enable
//
// state | meaning
// IDLE  | waiting for start
// RUN   | multiply iterations, one bit of B per cycle
// DONE  | result valid, done pulse
module alu_cc_unit #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset_al,
    input  logic              start,
    input  logic [1:0]        ALUK,
    input  logic              MUL,
    input  logic [DATA_W-1:0] SR1_OUT,
    input  logic [DATA_W-1:0] SR2_OUT,
    input  logic [15:0]       IR,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    output logic [DATA_W-1:0] ALU_out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        NZP,
    output logic              BEN
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] alu_out_q;
    logic [CNT_W-1:0]  cnt;
    logic              mul_last;
    logic              busy_q, done_q;
    logic [2:0]        nzp_q;
    logic              ben_q;
    logic              unused_ir;

    assign unused_ir = ^{IR[15:12], IR[8:6]};

    assign op_b = IR[5] ? {{(DATA_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]} : SR2_OUT;

    always_comb begin
        alu_res = '0;
        case (ALUK)
            2'b00:   alu_res = SR1_OUT + op_b;
            2'b01:   alu_res = SR1_OUT & op_b;
            2'b10:   alu_res = ~SR1_OUT;
            default: alu_res = SR1_OUT;
        endcase
    end

    // Only the low DATA_W bits of the product are kept, so the accumulator
    // and the shifted partial product never need extra width.
    assign mul_last = (cnt == CNT_W'(DATA_W-1));
    assign acc_nxt  = b_q[cnt] ? acc + (a_q << cnt) : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL ? RUN : DONE;
            RUN:     if (mul_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            alu_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (MUL) begin
                            a_q <= SR1_OUT;
                            b_q <= op_b;
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            alu_out_q <= alu_res;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (mul_last) alu_out_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    // BEN samples the NZP held before the edge, so a simultaneous LD_CC
    // does not feed into the same BEN update.
    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_BEN) ben_q <= |(IR[11:9] & nzp_q);
            if (LD_CC) begin
                if (bus_data[DATA_W-1])  nzp_q <= 3'b100;
                else if (bus_data == '0) nzp_q <= 3'b010;
                else                     nzp_q <= 3'b001;
            end
        end
    end

    assign ALU_out = alu_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign NZP     = nzp_q;
    assign BEN     = ben_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
module tb_alu_cc_unit;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic        start;
    logic [1:0]  ALUK;
    logic        MUL;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [15:0] IR;
    logic [15:0] bus_data;
    logic        LD_CC;
    logic        LD_BEN;
    logic [15:0] ALU_out;
    logic        busy;
    logic        done;
    logic [2:0]  NZP;
    logic        BEN;

    int checks = 0;
    int errors = 0;

    alu_cc_unit #(.DATA_W(16), .IMM_W(5)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .start(start), .ALUK(ALUK), .MUL(MUL),
        .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .IR(IR), .bus_data(bus_data),
        .LD_CC(LD_CC), .LD_BEN(LD_BEN), .ALU_out(ALU_out), .busy(busy),
        .done(done), .NZP(NZP), .BEN(BEN)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; ALUK = 0; MUL = 0; SR1_OUT = 0; SR2_OUT = 0;
        IR = 0; bus_data = 0; LD_CC = 0; LD_BEN = 0;
    endtask

    task automatic test_reset();
        Reset_al = 0;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); ALUK = 2'($urandom); MUL = 1'($urandom);
            SR1_OUT = 16'($urandom); SR2_OUT = 16'($urandom); IR = 16'($urandom);
            bus_data = 16'($urandom); LD_CC = 1'($urandom); LD_BEN = 1'($urandom);
            tick();
        end
        checks++; if (ALU_out !== 16'h0000) begin errors++; $display("FAIL reset_alu_out got %h want 0000", ALU_out); end
        checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b want 010", NZP); end
        checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL reset_ben got %b want 0", BEN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        idle_inputs();
        Reset_al = 1;
        tick();
    endtask

    task automatic test_add_reg();
        SR1_OUT = 16'h7FFF; SR2_OUT = 16'h0001; IR = 16'h0000; ALUK = 2'b00; start = 1;
        tick();
        start = 0; SR1_OUT = 16'h1111;
        checks++; if (ALU_out !== 16'h8000) begin errors++; $display("FAIL add_reg_result got %h want 8000", ALU_out); end
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL add_reg_done got done=%b busy=%b want 1 1", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_reg_idle got done=%b busy=%b want 0 0", done, busy); end
        bus_data = 16'h8000; LD_CC = 1;
        tick();
        LD_CC = 0;
        checks++; if (NZP !== 3'b100) begin errors++; $display("FAIL cc_negative got %b want 100", NZP); end
    endtask

    task automatic test_imm_logic();
        logic [1:0]  v_aluk [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [15:0] v_sr1  [4] = '{16'h0005, 16'h1234, 16'h00FF, 16'hBEEF};
        logic [15:0] v_ir   [4] = '{16'h0030, 16'h003F, 16'h0000, 16'h0000};
        logic [15:0] v_exp  [4] = '{16'hFFF5, 16'h1234, 16'hFF00, 16'hBEEF};
        for (int i = 0; i < 4; i++) begin
            ALUK = v_aluk[i]; SR1_OUT = v_sr1[i]; IR = v_ir[i]; SR2_OUT = 16'h5A5A; start = 1;
            tick();
            start = 0;
            checks++; if (ALU_out !== v_exp[i] || done !== 1'b1) begin
                errors++; $display("FAIL imm_logic_%0d got %h done=%b want %h done=1", i, ALU_out, done, v_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_multiply();
        int done_at = 0;
        int done_cnt = 0;
        int busy_cnt = 0;
        bit hold_bad = 0;
        SR1_OUT = 16'h0003; SR2_OUT = 16'hFFFF; IR = 16'h0000; MUL = 1; start = 1;
        tick();
        // cycle 1 is the cycle following the accepting edge
        SR1_OUT = 16'h1111; SR2_OUT = 16'h0000; start = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (done_at == 0 && ALU_out !== 16'hBEEF) hold_bad = 1;
            start = (k < 14) ? 1'(k % 2) : 1'b0;
            tick();
        end
        MUL = 0;
        checks++; if (ALU_out !== 16'hFFFD) begin errors++; $display("FAIL mul_result got %h want FFFD", ALU_out); end
        checks++; if (done_at != 17) begin errors++; $display("FAIL mul_latency got %0d want 17", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mul_done_pulses got %0d want 1", done_cnt); end
        checks++; if (busy_cnt != 17) begin errors++; $display("FAIL mul_busy_cycles got %0d want 17", busy_cnt); end
        checks++; if (hold_bad) begin errors++; $display("FAIL mul_hold got changed want BEEF held"); end
    endtask

    task automatic test_ben_simul();
        bus_data = 16'h0000; LD_CC = 1;
        tick();
        LD_CC = 0;
        checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL cc_zero got %b want 010", NZP); end
        IR = 16'h0400; bus_data = 16'h0001; LD_CC = 1; LD_BEN = 1;
        tick();
        LD_CC = 0;
        checks++; if (BEN !== 1'b1) begin errors++; $display("FAIL ben_simul got %b want 1", BEN); end
        checks++; if (NZP !== 3'b001) begin errors++; $display("FAIL cc_positive got %b want 001", NZP); end
        tick();
        LD_BEN = 0;
        checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL ben_reload got %b want 0", BEN); end
        IR = 16'h0000;
    endtask

    task automatic test_reset_mid_mul();
        bit run_bad = 0;
        int late_done = 0;
        SR1_OUT = 16'h0003; SR2_OUT = 16'h0005; IR = 16'h0000; MUL = 1; start = 1;
        tick();
        start = 0; MUL = 0;
        for (int k = 1; k < 8; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) run_bad = 1;
            tick();
        end
        checks++; if (run_bad) begin errors++; $display("FAIL mid_mul_run got early exit want busy"); end
        Reset_al = 0;
        tick();
        Reset_al = 1;
        checks++; if (busy !== 1'b0 || ALU_out !== 16'h0000 || done !== 1'b0) begin
            errors++; $display("FAIL mid_mul_reset got busy=%b out=%h done=%b want 0 0000 0", busy, ALU_out, done);
        end
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) late_done++;
            tick();
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL mid_mul_no_done got %0d pulses want 0", late_done); end
        SR1_OUT = 16'h0002; SR2_OUT = 16'h0003; ALUK = 2'b00; start = 1;
        tick();
        start = 0;
        checks++; if (ALU_out !== 16'h0005 || done !== 1'b1) begin
            errors++; $display("FAIL post_reset_add got %h done=%b want 0005 1", ALU_out, done);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        Reset_al = 0;
        #1;
        test_reset();
        test_add_reg();
        test_imm_logic();
        test_multiply();
        test_ben_simul();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
